sequence_player: RTL

Plays the current level's secret digit sequence out to the player before a guess is entered. It is the presenting end of the guessing game: the checker compares submitted 4-bit guesses against the sequence, and this block shows those same values for `level+1` digits. Each digit is held for a fixed time, with blanking gaps between digits. It sits between the level-control logic and the LED/7-segment display driver.

---
 rtl/game_pkg.sv | 20 ++
 rtl/sequence_player_if.sv | 25 ++
 rtl/sequence_player_seq_rom.sv | 19 +
 rtl/sequence_player.sv | 131 +++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared guessing-game definitions: default sizes, the secret sequence formula
// and the player state encoding, common to the player and the guess checker.
package game_pkg;

  localparam int unsigned SEQ_DEPTH   = 10;
  localparam int unsigned SEQ_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP,
    DONE
  } player_state_e;

  // Single source of truth for the secret sequence.
  function automatic logic [3:0] seq_value(input int unsigned i);
    return 4'((13 * i + 46) % 16);
  endfunction

endpackage

// File: rtl/sequence_player_if.sv
// Control/display bundle between level control (master) and the sequence player (slave).
interface sequence_player_if #(
  parameter int unsigned DIGIT_W = game_pkg::SEQ_DIGIT_W
) ();

  logic               start;
  logic               abort;
  logic [3:0]         level;
  logic [DIGIT_W-1:0] digit;
  logic               digit_valid;
  logic [3:0]         index;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, level,
    input  digit, digit_valid, index, busy, done
  );

  modport slave (
    input  start, abort, level,
    output digit, digit_valid, index, busy, done
  );

endinterface

// File: rtl/sequence_player_seq_rom.sv
// Combinational index-to-digit lookup built from game_pkg::seq_value.
module seq_rom
  import game_pkg::*;
#(
  parameter int unsigned DEPTH   = SEQ_DEPTH,
  parameter int unsigned DIGIT_W = SEQ_DIGIT_W
) (
  input  logic [3:0]         idx_i,
  output logic [DIGIT_W-1:0] value_o
);

  always_comb begin
    value_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (idx_i == 4'(i)) value_o = DIGIT_W'(seq_value(i));
    end
  end

endmodule

// File: rtl/sequence_player.sv
// Plays the level's secret digits with hold/gap timing to the display driver.
// Define SEQUENCE_PLAYER_LOOP_EN for endless looping playback (no done pulse).
module sequence_player
  import game_pkg::*;
#(
  parameter int unsigned DEPTH       = SEQ_DEPTH,
  parameter int unsigned DIGIT_W     = SEQ_DIGIT_W,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 12_500_000
) (
  input  logic             clk,
  input  logic             reset,
  sequence_player_if.slave bus
);

  localparam int unsigned MAX_CYC   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TW        = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
  localparam logic [3:0] LAST_MAX   = 4'(DEPTH - 1);

  player_state_e      state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         last_q, last_d;
  logic [DIGIT_W-1:0] rom_value;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic               valid_q, valid_d;
  logic [3:0]         index_q, index_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Looked up on the next index so the shown digit can be registered.
  seq_rom #(
    .DEPTH   (DEPTH),
    .DIGIT_W (DIGIT_W)
  ) u_rom (
    .idx_i   (idx_d),
    .value_o (rom_value)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          last_d  = ({28'd0, bus.level} >= DEPTH) ? LAST_MAX : bus.level;
          idx_d   = '0;
          timer_d = HOLD_LD;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (idx_q == last_q) begin
`ifdef SEQUENCE_PLAYER_LOOP_EN
          timer_d = GAP_LD;
          state_d = GAP;
`else
          state_d = DONE;
`endif
        end else begin
          timer_d = GAP_LD;
          state_d = GAP;
        end
      end
      GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          // Wrap only happens in looping builds; one-shot never gaps after the last digit.
          idx_d   = (idx_q == last_q) ? 4'd0 : idx_q + 4'd1;
          timer_d = HOLD_LD;
          state_d = SHOW;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.abort) begin
      state_d = IDLE;
      timer_d = '0;
      idx_d   = '0;
      last_d  = last_q;
    end

    // Outputs are decoded from the next state and registered alongside it.
    valid_d = (state_d == SHOW);
    busy_d  = (state_d == SHOW) || (state_d == GAP);
    digit_d = valid_d ? rom_value : '0;
    index_d = busy_d ? idx_d : '0;
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      digit_q <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      index_q <= index_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.digit       = digit_q;
  assign bus.digit_valid = valid_q;
  assign bus.index       = index_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
